// File: rtl/fifo_wr_packer_if.sv
// Stream-in / FIFO-write-out bundle for fifo_wr_packer.
//   in_valid/in_ready/in_data/in_last : narrow input stream (valid/ready)
//   fifo_full                         : FIFO full flag, wr_clk domain
//   wr_en/din                         : FIFO write port
// The packer uses the slave modport. The source and FIFO side use the master modport.
interface fifo_wr_packer_if #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 fifo_full;
  logic                 wr_en;
  logic [OUT_WIDTH-1:0] din;

  modport slave (
    input  in_valid, in_data, in_last, fifo_full,
    output in_ready, wr_en, din
  );

  modport master (
    output in_valid, in_data, in_last, fifo_full,
    input  in_ready, wr_en, din
  );
endinterface

// File: rtl/fifo_wr_packer.sv
// Write-side front end for the async FIFO. It packs RATIO narrow input words into one
// FIFO-width word. The first accepted word goes to lane 0, the lowest bits.
// When in_last arrives, any partial word is flushed, and its unfilled lanes are set to PAD_VAL.
// A single hold register feeds the FIFO write port. It can drain and reload on the same edge,
// so the block sustains one input word per cycle while the FIFO is not full.
// Ports:
//   wr_clk, rst_n : write clock, asynchronous active-low reset
//   clr           : synchronous soft clear (drops partial pack and hold word, zeroes wr_cnt)
//   bus           : stream input and FIFO write port (fifo_wr_packer_if.slave)
//   pkt_done      : high with the write that carries in_last
//   busy          : partial pack or hold word pending
//   wr_cnt        : FIFO writes since reset/clr, wraps
module fifo_wr_packer #(
  parameter int unsigned         IN_WIDTH  = 8,
  parameter int unsigned         RATIO     = 2,
  parameter int unsigned         OUT_WIDTH = IN_WIDTH * RATIO,
  parameter logic [IN_WIDTH-1:0] PAD_VAL   = '0,
  parameter int unsigned         CNT_WIDTH = 32
) (
  input  logic                 wr_clk,
  input  logic                 rst_n,
  input  logic                 clr,
  fifo_wr_packer_if.slave      bus,
  output logic                 pkt_done,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] wr_cnt
);

  localparam int unsigned     LaneW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(RATIO - 1);

  logic                 ready_en_q;
  logic [LaneW-1:0]     lane_q;
  logic [OUT_WIDTH-1:0] pack_q;
  logic [OUT_WIDTH-1:0] hold_q;
  logic                 hold_valid_q;
  logic                 hold_last_q;
  logic [CNT_WIDTH-1:0] wr_cnt_q;

  logic                 accept;
  logic                 complete;
  logic                 wr_en;
  logic [OUT_WIDTH-1:0] word;
  int unsigned          lane_u;

  assign lane_u   = 32'(lane_q);
  // Any pending hold word blocks input while the FIFO is full. The pack register then stays
  // frozen, so no data is lost or duplicated.
  assign bus.in_ready = ready_en_q & ~(hold_valid_q & bus.fifo_full);
  assign accept   = bus.in_valid & bus.in_ready;
  assign complete = accept & ((lane_q == LastLane) | bus.in_last);
  // clr discards the hold word, so it must not reach the FIFO in that cycle.
  assign wr_en    = hold_valid_q & ~bus.fifo_full & ~clr;

  assign bus.wr_en = wr_en;
  assign bus.din   = hold_q;
  assign pkt_done  = wr_en & hold_last_q;
  assign busy      = (lane_q != '0) | hold_valid_q;
  assign wr_cnt    = wr_cnt_q;

  // Word as it would look if completed by this cycle's input.
  // Lanes below the current lane come from the pack register.
  // The current lane takes in_data, and the lanes above it take the pad value.
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (i < lane_u) begin
        word[i*IN_WIDTH +: IN_WIDTH] = pack_q[i*IN_WIDTH +: IN_WIDTH];
      end else if (i == lane_u) begin
        word[i*IN_WIDTH +: IN_WIDTH] = bus.in_data;
      end else begin
        word[i*IN_WIDTH +: IN_WIDTH] = PAD_VAL;
      end
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q   <= 1'b0;
      lane_q       <= '0;
      pack_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      wr_cnt_q     <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (clr) begin
        lane_q       <= '0;
        hold_valid_q <= 1'b0;
        hold_last_q  <= 1'b0;
        wr_cnt_q     <= '0;
      end else begin
        if (accept) begin
          pack_q <= word;
          lane_q <= complete ? '0 : lane_q + LaneW'(1);
        end
        // A load wins over a drain on the same edge, which keeps the pipeline full.
        if (complete) begin
          hold_q       <= word;
          hold_valid_q <= 1'b1;
          hold_last_q  <= bus.in_last;
        end else if (wr_en) begin
          hold_valid_q <= 1'b0;
          hold_last_q  <= 1'b0;
        end
        if (wr_en) begin
          wr_cnt_q <= wr_cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  a_no_write_when_full: assert property (@(posedge wr_clk) disable iff (!rst_n)
    !(wr_en && bus.fifo_full));

endmodule

// File: tb/tb_fifo_wr_packer.sv
module tb_fifo_wr_packer;

  logic        wr_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        clr    = 1'b0;
  logic        pkt_done;
  logic        busy;
  logic [31:0] wr_cnt;

  int n_pass  = 0;
  int n_total = 0;

  fifo_wr_packer_if #(.IN_WIDTH(8), .OUT_WIDTH(16)) bus ();

  fifo_wr_packer #(
    .IN_WIDTH (8),
    .RATIO    (2),
    .OUT_WIDTH(16),
    .PAD_VAL  (8'h00),
    .CNT_WIDTH(32)
  ) dut (
    .wr_clk  (wr_clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .bus     (bus),
    .pkt_done(pkt_done),
    .busy    (busy),
    .wr_cnt  (wr_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        last;
    logic        full;
    logic        clr;
    logic        ready;
    logic        wr_en;
    logic [15:0] din;
    logic        pkt;
    logic        busy;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic l, input logic f,
                     input logic c, input logic rdy, input logic we, input logic [15:0] dn,
                     input logic pk, input logic bz, input logic [31:0] cn);
    vec_t t;
    t.valid = v; t.data = d; t.last = l; t.full = f; t.clr = c;
    t.ready = rdy; t.wr_en = we; t.din = dn; t.pkt = pk; t.busy = bz; t.cnt = cn;
    vecs.push_back(t);
  endtask

  task automatic check_outputs(input string tag, input logic rdy, input logic we,
                               input logic [15:0] dn, input logic pk, input logic bz,
                               input logic [31:0] cn);
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(rdy));
    check({tag, ".wr_en"},    64'(bus.wr_en),    64'(we));
    check({tag, ".din"},      64'(bus.din),      64'(dn));
    check({tag, ".pkt_done"}, 64'(pkt_done),     64'(pk));
    check({tag, ".busy"},     64'(busy),         64'(bz));
    check({tag, ".wr_cnt"},   64'(wr_cnt),       64'(cn));
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic f,
                       input logic c);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.fifo_full = f;
    clr           = c;
  endtask

  initial begin
    int          acc;
    int          writes;
    bit          have_lo;
    logic [7:0]  lo;
    logic [15:0] expq[$];

    // Fields: valid data last full clr | ready wr_en din pkt busy cnt
    add(1, 8'h11, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 0); // ready_en not yet set
    add(1, 8'h11, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0);
    add(1, 8'h22, 0, 0, 0,  1, 0, 16'h0000, 0, 1, 0);
    add(0, 8'h00, 0, 0, 0,  1, 1, 16'h2211, 0, 1, 0); // T1 write
    add(1, 8'h33, 1, 0, 0,  1, 0, 16'h2211, 0, 0, 1);
    add(0, 8'h00, 0, 0, 0,  1, 1, 16'h0033, 1, 1, 1); // T2 padded flush
    add(0, 8'h00, 0, 0, 0,  1, 0, 16'h0033, 0, 0, 2);
    add(1, 8'h44, 0, 0, 0,  1, 0, 16'h0033, 0, 0, 2);
    add(1, 8'h55, 0, 0, 0,  1, 0, 16'h0033, 0, 1, 2);
    for (int i = 0; i < 5; i++) begin
      add(1, 8'h66, 0, 1, 0, 0, 0, 16'h5544, 0, 1, 2); // T3 blocked by full
    end
    add(0, 8'h00, 0, 0, 0,  1, 1, 16'h5544, 0, 1, 2);
    add(0, 8'h00, 0, 0, 0,  1, 0, 16'h5544, 0, 0, 3);
    add(1, 8'h77, 0, 0, 0,  1, 0, 16'h5544, 0, 0, 3);
    add(1, 8'h88, 0, 0, 0,  1, 0, 16'h5544, 0, 1, 3);
    add(1, 8'h99, 0, 0, 0,  1, 1, 16'h8877, 0, 1, 3); // drain while filling
    add(1, 8'hAA, 0, 0, 0,  1, 0, 16'h8877, 0, 1, 4);
    add(1, 8'hBB, 1, 0, 0,  1, 1, 16'hAA99, 0, 1, 4); // drain and load same edge
    add(0, 8'h00, 0, 0, 0,  1, 1, 16'h00BB, 1, 1, 5);
    add(1, 8'hCC, 0, 0, 0,  1, 0, 16'h00BB, 0, 0, 6);
    add(1, 8'hDD, 0, 0, 0,  1, 0, 16'h00BB, 0, 1, 6);
    add(0, 8'h00, 0, 1, 0,  0, 0, 16'hDDCC, 0, 1, 6);
    add(0, 8'h00, 0, 1, 1,  0, 0, 16'hDDCC, 0, 1, 6); // T6 clr while full
    add(0, 8'h00, 0, 0, 0,  1, 0, 16'hDDCC, 0, 0, 0);
    add(1, 8'h01, 0, 0, 0,  1, 0, 16'hDDCC, 0, 0, 0);
    add(1, 8'h02, 0, 0, 0,  1, 0, 16'hDDCC, 0, 1, 0);
    add(0, 8'h00, 0, 0, 1,  1, 0, 16'h0201, 0, 1, 0); // clr with full=0 masks wr_en
    add(0, 8'h00, 0, 0, 0,  1, 0, 16'h0201, 0, 0, 0);
    add(1, 8'h03, 0, 0, 0,  1, 0, 16'h0201, 0, 0, 0);
    add(1, 8'h04, 0, 0, 1,  1, 0, 16'h0201, 0, 1, 0); // clr beats completing accept
    add(0, 8'h00, 0, 0, 0,  1, 0, 16'h0201, 0, 0, 0);

    drive(0, 8'h00, 0, 0, 0);
    repeat (3) @(negedge wr_clk);
    check_outputs("reset", 0, 0, 16'h0000, 0, 0, 0);

    @(negedge wr_clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].full, vecs[i].clr);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].ready, vecs[i].wr_en, vecs[i].din,
                    vecs[i].pkt, vecs[i].busy, vecs[i].cnt);
      @(negedge wr_clk);
    end

    // T5: asynchronous reset after one accepted word
    drive(1, 8'hAA, 0, 0, 0);
    @(negedge wr_clk);
    drive(0, 8'h00, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_outputs("t5_reset", 0, 0, 16'h0000, 0, 0, 0);
    @(negedge wr_clk);
    rst_n = 1'b1;
    #1;
    check("t5_ready_after_release", 64'(bus.in_ready), 64'd0);
    @(negedge wr_clk);
    drive(1, 8'h01, 0, 0, 0);
    #1;
    check("t5_ready_on", 64'(bus.in_ready), 64'd1);
    @(negedge wr_clk);
    drive(1, 8'h02, 0, 0, 0);
    @(negedge wr_clk);
    drive(0, 8'h00, 0, 0, 0);
    #1;
    check_outputs("t5_pair", 1, 1, 16'h0201, 0, 1, 0);
    @(negedge wr_clk);
    #1;
    check("t5_cnt", 64'(wr_cnt), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    drive(0, 8'h00, 0, 0, 1);
    @(negedge wr_clk);
    drive(0, 8'h00, 0, 0, 0);
    #1;
    check("clr_cnt", 64'(wr_cnt), 64'd0);

    // T4: 256 random words under random full, checked against a packing scoreboard
    acc = 0;
    writes = 0;
    have_lo = 1'b0;
    lo = 8'h00;
    for (int cyc = 0; cyc < 5000 && writes < 128; cyc++) begin
      @(negedge wr_clk);
      drive(logic'((acc < 256) && ($urandom_range(3) != 0)), 8'($urandom), 0,
            logic'($urandom_range(9) < 3), 0);
      #1;
      check("t4_wr_en_while_full", 64'(bus.wr_en & bus.fifo_full), 64'd0);
      if (bus.wr_en) begin
        if (expq.size() == 0) begin
          check("t4_spurious_write", 64'd1, 64'd0);
        end else begin
          check($sformatf("t4_din%0d", writes), 64'(bus.din), 64'(expq.pop_front()));
        end
        writes++;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (have_lo) begin
          expq.push_back({bus.in_data, lo});
        end else begin
          lo = bus.in_data;
        end
        have_lo = ~have_lo;
        acc++;
      end
    end
    @(negedge wr_clk);
    drive(0, 8'h00, 0, 0, 0);
    #1;
    check("t4_accepted", 64'(acc), 64'd256);
    check("t4_writes", 64'(writes), 64'd128);
    check("t4_queue_empty", 64'(expq.size()), 64'd0);
    check("t4_wr_cnt", 64'(wr_cnt), 64'd128);
    check("t4_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
